// File: rtl/disp_pkg.sv
// disp_pkg: shared definitions for the display arbiter slice.
//   - source encodings driven on src
//   - arbiter FSM state type
//   - digit geometry (DIGITS x DIGIT_W) and the largest legal BCD value
//   - cnt_w(): counter width helper, never returns 0 so single-value
//     counters still have a legal one-bit register
package disp_pkg;

    localparam int DIGITS  = 6;
    localparam int DIGIT_W = 4;
    localparam int WORD_W  = DIGITS * DIGIT_W;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    localparam logic [1:0] SRC_TIME = 2'd0;
    localparam logic [1:0] SRC_EDIT = 2'd1;
    localparam logic [1:0] SRC_MSG  = 2'd2;

    typedef enum logic [1:0] {
        S_TIME = 2'd0,
        S_EDIT = 2'd1,
        S_MSG  = 2'd2
    } disp_state_t;

    // Width needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// disp_arbiter_if: request/display bundle between the timer core, the
// arbiter and the LED encoder.
//   time_val, edit_en, edit_val, edit_pos, msg_req, msg_val : requests
//   digits, blank, src, msg_busy, msg_done                  : display side
// Modports:
//   master - the requesting side (drives requests, observes display)
//   slave  - the arbiter
interface disp_arbiter_if;
    import disp_pkg::*;

    logic [WORD_W-1:0] time_val;
    logic              edit_en;
    logic [WORD_W-1:0] edit_val;
    logic [2:0]        edit_pos;
    logic              msg_req;
    logic [WORD_W-1:0] msg_val;

    logic [WORD_W-1:0] digits;
    logic [DIGITS-1:0] blank;
    logic [1:0]        src;
    logic              msg_busy;
    logic              msg_done;

    modport master (
        output time_val, edit_en, edit_val, edit_pos, msg_req, msg_val,
        input  digits, blank, src, msg_busy, msg_done
    );

    modport slave (
        input  time_val, edit_en, edit_val, edit_pos, msg_req, msg_val,
        output digits, blank, src, msg_busy, msg_done
    );

endinterface

// File: rtl/disp_arbiter_ms_tick.sv
// ms_tick: millisecond prescaler. Emits a one-cycle tick every DIV cycles.
// Ports:
//   clk     - clock
//   rst     - asynchronous reset, active low
//   restart - synchronous realign: counter returns to 0, no tick this cycle,
//             so the next tick lands exactly DIV cycles later
//   tick    - one-cycle pulse
module ms_tick
    import disp_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int            W    = cnt_w(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);
    localparam logic [W-1:0]  ONE  = W'(1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        tick     = 1'b0;
        cnt_next = cnt_reg;
        if (restart) begin
            cnt_next = '0;
        end else if (cnt_reg == LAST) begin
            tick     = 1'b1;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: selects running time, edit mode (blinking cursor) or a
// transient message for the 6-digit seven-segment encoder, and owns the
// blink and message timing.
// Parameters: CLK_HZ (clock in Hz, multiple of 1000), BLINK_MS (cursor
// half-period), MSG_MS (message display time).
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active low
//   bus  - disp_arbiter_if.slave (requests in, registered display out)
// Optional feature: define DISP_LZ_BLANK_EN to blank leading zeros while
// the running time is shown.
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_MS = 250,
    parameter int MSG_MS   = 2000
) (
    input  logic           clk,
    input  logic           rst,
    disp_arbiter_if.slave  bus
);

    localparam int TICK_DIV = CLK_HZ / 1000;

    localparam int                MSG_W      = cnt_w(MSG_MS);
    localparam logic [MSG_W-1:0]  MSG_LAST   = MSG_W'(MSG_MS - 1);
    localparam logic [MSG_W-1:0]  MSG_ONE    = MSG_W'(1);
    localparam int                BLINK_W    = cnt_w(BLINK_MS);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    disp_state_t state_reg, state_next;

    logic [WORD_W-1:0]  msg_val_reg;
    logic [MSG_W-1:0]   msg_cnt_reg, msg_cnt_next;
    logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic               phase_reg, phase_next;
    logic [2:0]         edit_pos_reg;

    logic [WORD_W-1:0]  digits_reg, digits_next;
    logic [DIGITS-1:0]  blank_reg, blank_next;
    logic [1:0]         src_reg, src_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic               msg_tick, blink_tick;
    logic               msg_timeout;
    logic               edit_next, blink_clr, blink_to;

    logic [WORD_W-1:0]  raw_word;
    logic [WORD_W-1:0]  clean_word;
    logic [DIGITS-1:0]  dig_bad;

    // Message prescaler realigns on every latch so the timeout is exact.
    ms_tick #(.DIV(TICK_DIV)) u_msg_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (bus.msg_req),
        .tick    (msg_tick)
    );

    // Blink prescaler realigns whenever the blink phase is cleared.
    ms_tick #(.DIV(TICK_DIV)) u_blink_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (blink_clr),
        .tick    (blink_tick)
    );

    assign msg_timeout = (state_reg == S_MSG) && msg_tick && (msg_cnt_reg == MSG_LAST);

    // Next state. A new request always wins over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_TIME: begin
                if (bus.msg_req)      state_next = S_MSG;
                else if (bus.edit_en) state_next = S_EDIT;
            end
            S_EDIT: begin
                if (bus.msg_req)       state_next = S_MSG;
                else if (!bus.edit_en) state_next = S_TIME;
            end
            S_MSG: begin
                if (bus.msg_req)      state_next = S_MSG;
                else if (msg_timeout) state_next = bus.edit_en ? S_EDIT : S_TIME;
            end
            default: state_next = S_TIME;
        endcase
    end

    // Message millisecond counter; reloaded by a request or at the last ms.
    always_comb begin
        msg_cnt_next = msg_cnt_reg;
        if (bus.msg_req) begin
            msg_cnt_next = '0;
        end else if (state_reg == S_MSG && msg_tick) begin
            msg_cnt_next = (msg_cnt_reg == MSG_LAST) ? '0 : msg_cnt_reg + MSG_ONE;
        end
    end

    // Blink: cleared on entry to edit mode and whenever the cursor moves,
    // so the cursor digit is lit straight away.
    assign edit_next = (state_next == S_EDIT);
    assign blink_clr = edit_next && ((state_reg != S_EDIT) || (bus.edit_pos != edit_pos_reg));
    assign blink_to  = edit_next && !blink_clr && blink_tick && (blink_cnt_reg == BLINK_LAST);

    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        if (!edit_next || blink_clr) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_tick) begin
            blink_cnt_next = (blink_cnt_reg == BLINK_LAST) ? '0 : blink_cnt_reg + BLINK_ONE;
            if (blink_to) phase_next = ~phase_reg;
        end
    end

    // Source word follows the next state so outputs lag inputs by one cycle.
    // A message arriving this cycle is shown directly from msg_val.
    always_comb begin
        raw_word = bus.time_val;
        src_next = SRC_TIME;
        unique case (state_next)
            S_TIME: begin
                raw_word = bus.time_val;
                src_next = SRC_TIME;
            end
            S_EDIT: begin
                raw_word = bus.edit_val;
                src_next = SRC_EDIT;
            end
            S_MSG: begin
                raw_word = bus.msg_req ? bus.msg_val : msg_val_reg;
                src_next = SRC_MSG;
            end
            default: begin
                raw_word = bus.time_val;
                src_next = SRC_TIME;
            end
        endcase
    end

    // Non-BCD digits are forced to 0 and darkened.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] raw_dig;
            assign raw_dig = raw_word[gi*DIGIT_W +: DIGIT_W];
            assign dig_bad[gi] = (raw_dig > BCD_MAX);
            assign clean_word[gi*DIGIT_W +: DIGIT_W] = dig_bad[gi] ? '0 : raw_dig;
        end
    endgenerate

    always_comb begin
        blank_next = dig_bad;
        if (edit_next && phase_next && (bus.edit_pos <= 3'd5)) begin
            blank_next[bus.edit_pos] = 1'b1;
        end
`ifdef DISP_LZ_BLANK_EN
        // Leading-zero run is judged on the sanitised digits; digit 0 stays lit.
        if (state_next == S_TIME) begin
            logic lz_run;
            lz_run = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                lz_run = lz_run && (clean_word[i*DIGIT_W +: DIGIT_W] == '0);
                if (lz_run) blank_next[i] = 1'b1;
            end
        end
`endif
    end

    assign digits_next = clean_word;
    assign busy_next   = (state_next == S_MSG);
    assign done_next   = msg_timeout && !bus.msg_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_TIME;
            msg_val_reg   <= '0;
            msg_cnt_reg   <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            edit_pos_reg  <= '0;
            digits_reg    <= '0;
            blank_reg     <= '0;
            src_reg       <= SRC_TIME;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            if (bus.msg_req) msg_val_reg <= bus.msg_val;
            msg_cnt_reg   <= msg_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
            phase_reg     <= phase_next;
            edit_pos_reg  <= bus.edit_pos;
            digits_reg    <= digits_next;
            blank_reg     <= blank_next;
            src_reg       <= src_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign bus.digits   = digits_reg;
    assign bus.blank    = blank_reg;
    assign bus.src      = src_reg;
    assign bus.msg_busy = busy_reg;
    assign bus.msg_done = done_reg;

endmodule
